// File: rtl/inv_bank_inertial.sv
// rtl/inv_bank_inertial.sv - N-channel inverter/buffer bank with clock-counted inertial or transport delay
module inv_bank_inertial #(
  parameter int          N        = 6,
  parameter int          DELAY    = 9,
  parameter logic [N-1:0] INV_MASK = {N{1'b1}},
  parameter logic [N-1:0] IC       = {N{1'b0}},
  parameter bit          INERTIAL = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] a,
  output logic [N-1:0] y,
  output logic [N-1:0] pending,
  input  logic         glitch_clr,
  output logic [15:0]  glitch_cnt
);

  localparam int CW = $clog2(DELAY + 1);

  logic [N-1:0] t;
  logic [N-1:0] yq;
  logic [N-1:0] pend_raw;
  logic [N-1:0] abandon;
  logic [5:0]   nglitch;
  logic [16:0]  gsum;
  logic [15:0]  gq;

  assign t          = a ^ INV_MASK;
  assign y          = yq;
  assign pending    = rst ? '0 : pend_raw;
  assign glitch_cnt = gq;

  generate
    if (INERTIAL) begin : g_inertial
      logic [CW-1:0] cnt [N];

      // A channel only commits after t has differed from y for DELAY sampled edges.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          yq <= IC;
          for (int i = 0; i < N; i++) cnt[i] <= '0;
        end else begin
          for (int i = 0; i < N; i++) begin
            if (t[i] == yq[i]) begin
              cnt[i] <= '0;
            end else if (cnt[i] == CW'(DELAY - 1)) begin
              yq[i]  <= t[i];
              cnt[i] <= '0;
            end else begin
              cnt[i] <= cnt[i] + 1'b1;
            end
          end
        end
      end

      always_comb begin
        abandon = '0;
        for (int i = 0; i < N; i++) abandon[i] = (t[i] == yq[i]) && (cnt[i] != '0);
      end

      assign pend_raw = t ^ yq;
    end else begin : g_transport
      // Stage 0 takes t, stage DELAY-1 drives y.
      logic [DELAY-1:0] sr [N];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < N; i++) sr[i] <= {DELAY{IC[i]}};
        end else begin
          for (int i = 0; i < N; i++) begin
            sr[i][0] <= t[i];
            for (int k = 1; k < DELAY; k++) sr[i][k] <= sr[i][k-1];
          end
        end
      end

      always_comb begin
        yq       = '0;
        pend_raw = '0;
        for (int i = 0; i < N; i++) begin
          yq[i]       = sr[i][DELAY-1];
          pend_raw[i] = |(sr[i] ^ {DELAY{sr[i][DELAY-1]}});
        end
      end

      assign abandon = '0;
    end
  endgenerate

  always_comb begin
    nglitch = '0;
    for (int i = 0; i < N; i++) nglitch = nglitch + 6'(abandon[i]);
    gsum = {1'b0, gq} + {11'd0, nglitch};
  end

  // Clear beats a same-edge increment; the sum saturates instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             gq <= '0;
    else if (glitch_clr) gq <= '0;
    else if (gsum[16])   gq <= 16'hFFFF;
    else                 gq <= gsum[15:0];
  end

endmodule
